layer2_window_fetch: RTL and testbench

Downstream consumer of the layer-1 result/pool memory. After 2x2 max-pooling completes, it walks the 14x14 pooled grid of all 8 channels. For each output position it fetches a zero-padded 3x3 window through the memory's two-port load interface (load, addr1, addr2, data01..data72). It presents the assembled 8-channel window to the layer-2 convolution engine over a valid/ready handshake.

---
 rtl/layer2_pkg.sv | 14 +
 rtl/layer2_window_fetch_tap_addr.sv | 37 +++
 rtl/layer2_window_fetch.sv | 164 ++++++++++++++++
 tb/tb_layer2_window_fetch.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/layer2_pkg.sv
// Shared constants and FSM encoding for the layer-2 window fetcher.
package layer2_pkg;
  localparam int IN_DIM     = 14;
  localparam int ROW_STRIDE = 56;
  localparam int COL_STRIDE = 2;
  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 10;
  localparam int NUM_CH     = 8;
  localparam int TAPS       = 9;
  localparam int WIN_W      = NUM_CH * TAPS * DATA_W;
  localparam int LAST_PHASE = 5;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FIN} state_t;
endpackage

// File: rtl/layer2_window_fetch_tap_addr.sv
// Maps (window row, window col, tap) to a pooled-memory address plus a padding flag.
module l2_tap_addr
  import layer2_pkg::*;
(
  input  logic [3:0]        row,
  input  logic [3:0]        col,
  input  logic [3:0]        tap,
  output logic [ADDR_W-1:0] addr,
  output logic              pad
);
  localparam logic signed [5:0] MAX_RC = 6'(IN_DIM - 1);

  logic [1:0]        dr;
  logic [1:0]        dc;
  logic              tap_ok;
  logic signed [5:0] r;
  logic signed [5:0] c;

  always_comb begin
    tap_ok = 1'b1;
    dc     = 2'd0;
    dr     = (tap < 4'd3) ? 2'd0 : (tap < 4'd6) ? 2'd1 : 2'd2;
    case (tap)
      4'd0, 4'd3, 4'd6: dc = 2'd0;
      4'd1, 4'd4, 4'd7: dc = 2'd1;
      4'd2, 4'd5, 4'd8: dc = 2'd2;
      default:          tap_ok = 1'b0;
    endcase
    // Window is centred on (row, col), so taps reach one pixel either side.
    r    = $signed({2'b00, row}) + $signed({4'b0000, dr}) - 6'sd1;
    c    = $signed({2'b00, col}) + $signed({4'b0000, dc}) - 6'sd1;
    pad  = !tap_ok || (r < 6'sd0) || (r > MAX_RC) || (c < 6'sd0) || (c > MAX_RC);
    addr = '0;
    if (!pad)
      addr = ADDR_W'(r[3:0]) * ADDR_W'(ROW_STRIDE) + ADDR_W'(c[3:0]) * ADDR_W'(COL_STRIDE);
  end
endmodule

// File: rtl/layer2_window_fetch.sv
// Walks the 14x14 pooled grid, fetches zero-padded 3x3x8 windows two taps per cycle,
// and offers each window to the layer-2 engine over valid/ready.
module layer2_window_fetch
  import layer2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     load,
  output logic [ADDR_W-1:0]        addr1,
  output logic [ADDR_W-1:0]        addr2,
  input  logic signed [DATA_W-1:0] data01,
  input  logic signed [DATA_W-1:0] data11,
  input  logic signed [DATA_W-1:0] data21,
  input  logic signed [DATA_W-1:0] data31,
  input  logic signed [DATA_W-1:0] data41,
  input  logic signed [DATA_W-1:0] data51,
  input  logic signed [DATA_W-1:0] data61,
  input  logic signed [DATA_W-1:0] data71,
  input  logic signed [DATA_W-1:0] data02,
  input  logic signed [DATA_W-1:0] data12,
  input  logic signed [DATA_W-1:0] data22,
  input  logic signed [DATA_W-1:0] data32,
  input  logic signed [DATA_W-1:0] data42,
  input  logic signed [DATA_W-1:0] data52,
  input  logic signed [DATA_W-1:0] data62,
  input  logic signed [DATA_W-1:0] data72,
  output logic                     win_valid,
  input  logic                     win_ready,
  output logic [WIN_W-1:0]         win_data,
  output logic [3:0]               win_row,
  output logic [3:0]               win_col
);
  localparam logic [3:0] LAST_RC = 4'(IN_DIM - 1);

  state_t            state_reg, state_next;
  logic [2:0]        phase_reg, phase_next;
  logic [3:0]        row_reg, row_next;
  logic [3:0]        col_reg, col_next;
  logic [ADDR_W-1:0] addr1_reg, addr2_reg;
  logic              pad1_reg, pad2_reg;
  logic [WIN_W-1:0]  win_reg;

  logic [ADDR_W-1:0] tap_addr1, tap_addr2;
  logic              tap_pad1, tap_pad2;
  logic              capture;
  logic [2:0]        cap_pair;

  logic signed [DATA_W-1:0] d1 [NUM_CH];
  logic signed [DATA_W-1:0] d2 [NUM_CH];

  assign d1[0] = data01;  assign d2[0] = data02;
  assign d1[1] = data11;  assign d2[1] = data12;
  assign d1[2] = data21;  assign d2[2] = data22;
  assign d1[3] = data31;  assign d2[3] = data32;
  assign d1[4] = data41;  assign d2[4] = data42;
  assign d1[5] = data51;  assign d2[5] = data52;
  assign d1[6] = data61;  assign d2[6] = data62;
  assign d1[7] = data71;  assign d2[7] = data72;

  l2_tap_addr u_tap1 (.row(row_reg), .col(col_reg), .tap({phase_reg, 1'b0}),
                      .addr(tap_addr1), .pad(tap_pad1));
  l2_tap_addr u_tap2 (.row(row_reg), .col(col_reg), .tap({phase_reg, 1'b1}),
                      .addr(tap_addr2), .pad(tap_pad2));

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    row_next   = row_reg;
    col_next   = col_reg;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    win_valid  = 1'b0;
    case (state_reg)
      IDLE: if (start) begin
        state_next = FETCH;
        phase_next = '0;
        row_next   = '0;
        col_next   = '0;
      end
      FETCH: begin
        busy = 1'b1;
        load = (phase_reg != 3'(LAST_PHASE));
        if (phase_reg == 3'(LAST_PHASE)) begin
          state_next = HOLD;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 3'd1;
        end
      end
      HOLD: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (win_ready) begin
          if (row_reg == LAST_RC && col_reg == LAST_RC) begin
            state_next = FIN;
          end else begin
            state_next = FETCH;
            if (col_reg == LAST_RC) begin
              col_next = '0;
              row_next = row_reg + 4'd1;
            end else begin
              col_next = col_reg + 4'd1;
            end
          end
        end
      end
      FIN: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Addresses are held between load strobes so the memory bus stays quiet.
  assign addr1    = load ? tap_addr1 : addr1_reg;
  assign addr2    = load ? tap_addr2 : addr2_reg;
  assign capture  = (state_reg == FETCH) && (phase_reg != 3'd0);
  assign cap_pair = phase_reg - 3'd1;
  assign win_data = win_reg;
  assign win_row  = row_reg;
  assign win_col  = col_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      row_reg   <= '0;
      col_reg   <= '0;
      addr1_reg <= '0;
      addr2_reg <= '0;
      pad1_reg  <= 1'b0;
      pad2_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
      if (load) begin
        addr1_reg <= tap_addr1;
        addr2_reg <= tap_addr2;
        pad1_reg  <= tap_pad1;
        pad2_reg  <= tap_pad2;
      end
    end
  end

  // Data returned for the previous load cycle lands in its tap slots; pad flags travel with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_reg <= '0;
    end else if (capture) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        win_reg[(ch*TAPS + 2*int'(cap_pair))*DATA_W +: DATA_W] <= pad1_reg ? '0 : d1[ch];
        if (cap_pair != 3'd4)
          win_reg[(ch*TAPS + 2*int'(cap_pair) + 1)*DATA_W +: DATA_W] <= pad2_reg ? '0 : d2[ch];
      end
    end
  end
endmodule

// File: tb/tb_layer2_window_fetch.sv
// Directed bench: memory model feeding the fetcher, full raster pass, backpressure, reset abort.
module tb_layer2_window_fetch;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         busy, done, load, win_valid, win_ready;
  logic [9:0]   addr1, addr2;
  logic [7:0]   d1 [8];
  logic [7:0]   d2 [8];
  logic [575:0] win_data;
  logic [3:0]   win_row, win_col;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer2_window_fetch dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .load(load),
    .addr1(addr1), .addr2(addr2),
    .data01(d1[0]), .data11(d1[1]), .data21(d1[2]), .data31(d1[3]),
    .data41(d1[4]), .data51(d1[5]), .data61(d1[6]), .data71(d1[7]),
    .data02(d2[0]), .data12(d2[1]), .data22(d2[2]), .data32(d2[3]),
    .data42(d2[4]), .data52(d2[5]), .data62(d2[6]), .data72(d2[7]),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .win_row(win_row), .win_col(win_col)
  );

  // Memory contents: addr[7:0]^ch, except channel 3 address 0 holds a negative pixel.
  function automatic logic [7:0] memval(input logic [9:0] a, input int ch);
    if (ch == 3 && a == 10'd0) return 8'h80;
    return a[7:0] ^ 8'(ch);
  endfunction

  always @(posedge clk) begin
    if (load) begin
      for (int ch = 0; ch < 8; ch++) begin
        d1[ch] <= memval(addr1, ch);
        d2[ch] <= memval(addr2, ch);
      end
    end
  end

  function automatic logic [575:0] exp_win(input int wr, input int wc);
    logic [575:0] w;
    w = '0;
    for (int ch = 0; ch < 8; ch++) begin
      for (int t = 0; t < 9; t++) begin
        int r, c;
        r = wr - 1 + t / 3;
        c = wc - 1 + t % 3;
        if (r >= 0 && r <= 13 && c >= 0 && c <= 13)
          w[(ch*9+t)*8 +: 8] = memval(10'(r*56 + c*2), ch);
      end
    end
    return w;
  endfunction

  function automatic logic [7:0] get_byte(input logic [575:0] w, input int ch, input int t);
    return w[(ch*9+t)*8 +: 8];
  endfunction

  task automatic check(input string tag, input logic [575:0] got, input logic [575:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int           a1_00 [5] = '{0, 0, 0, 0, 58};
  int           a2_00 [5] = '{0, 0, 2, 56, 0};
  int           a1_57 [5] = '{236, 240, 294, 348, 352};
  int           a2_57 [5] = '{238, 292, 296, 350, 0};
  logic [575:0] snap;
  int           s;

  initial begin
    rst = 1'b0; start = 1'b0; win_ready = 1'b1;
    for (int ch = 0; ch < 8; ch++) begin d1[ch] = '0; d2[ch] = '0; end
    repeat (3) tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_load", load, 0);
    check("rst_valid", win_valid, 0);
    check("rst_addr1", addr1, 0);
    check("rst_addr2", addr2, 0);
    check("rst_data", win_data, 0);
    check("rst_row", win_row, 0);
    check("rst_col", win_col, 0);
    rst = 1'b1;
    tick();

    // Full pass; s is the cycle in which start is sampled.
    s = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int w = 0; w < 196; w++) begin
      for (int k = 0; k < 6; k++) begin
        check("fetch_busy", busy, 1);
        check("fetch_load", load, (k < 5) ? 1 : 0);
        check("fetch_valid", win_valid, 0);
        if (w == 0 && k < 5) begin
          check("addr1_00", addr1, a1_00[k]);
          check("addr2_00", addr2, a2_00[k]);
        end
        if (w == 77 && k < 5) begin
          check("addr1_57", addr1, a1_57[k]);
          check("addr2_57", addr2, a2_57[k]);
        end
        if (w == 40 && k == 2) start = 1'b1;
        if (w == 40 && k == 3) start = 1'b0;
        tick();
      end
      // HOLD cycle: 7 cycles after the window's first fetch cycle minus one.
      check("hold_valid", win_valid, 1);
      check("hold_row", win_row, w / 14);
      check("hold_col", win_col, w % 14);
      check("hold_data", win_data, exp_win(w / 14, w % 14));
      if (w == 0) begin
        check("pad_ch1_t0", get_byte(win_data, 1, 0), 0);
        check("pad_ch1_t3", get_byte(win_data, 1, 3), 0);
        check("pad_ch1_t6", get_byte(win_data, 1, 6), 0);
        check("ch1_t4", get_byte(win_data, 1, 4), 1);
        check("ch0_t5", get_byte(win_data, 0, 5), 2);
        check("ch0_t7", get_byte(win_data, 0, 7), 56);
        check("ch0_t8", get_byte(win_data, 0, 8), 58);
        check("ch2_t8", get_byte(win_data, 2, 8), 56);
        check("ch7_t7", get_byte(win_data, 7, 7), 63);
        check("neg_ch3_t4", get_byte(win_data, 3, 4), 8'h80);
      end
      if (w == 31) begin
        win_ready = 1'b0;
        snap = win_data;
        repeat (10) begin
          tick();
          check("bp_valid", win_valid, 1);
          check("bp_load", load, 0);
          check("bp_data", win_data, snap);
          check("bp_row", win_row, 2);
          check("bp_col", win_col, 3);
        end
        win_ready = 1'b1;
      end
      tick();
    end
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    // 196*7+1 cycles plus the 10 backpressure stall cycles.
    check("fin_cycles", 576'(cyc - s), 196*7 + 1 + 10);
    tick();
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_valid", win_valid, 0);

    // Reset in the middle of a fetch, then restart cleanly.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("pre_rst_load", load, 1);
    rst = 1'b0;
    tick();
    check("ar_busy", busy, 0);
    check("ar_load", load, 0);
    check("ar_valid", win_valid, 0);
    check("ar_addr1", addr1, 0);
    check("ar_addr2", addr2, 0);
    check("ar_data", win_data, 0);
    check("ar_row", win_row, 0);
    check("ar_col", win_col, 0);
    rst = 1'b1;
    repeat (3) begin
      tick();
      check("idle_valid", win_valid, 0);
      check("idle_busy", busy, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      check("re_valid", win_valid, 0);
      tick();
    end
    check("re_valid_hi", win_valid, 1);
    check("re_row", win_row, 0);
    check("re_col", win_col, 0);
    check("re_data", win_data, exp_win(0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
